// File: rtl/shifter.sv
// Single-stage registered shifter: pass, lsl1, lsr1 or asr1 under a 2-bit opcode.
// The result, the shifted-out bit and a zero flag are registered, with a valid bit alongside.
module shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] sout,
    output logic             cout,
    output logic             zero,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_LSL  = 2'b01,
        OP_LSR  = 2'b10,
        OP_ASR  = 2'b11
    } op_t;

    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_zero;

    logic [WIDTH-1:0] r_sout;
    logic             r_cout;
    logic             r_zero;
    logic             r_valid;

    always_comb begin
        w_result = in;
        w_cout   = 1'b0;
        case (op_t'(shift))
            OP_PASS: begin
                w_result = in;
                w_cout   = 1'b0;
            end
            OP_LSL: begin
                w_result = {in[WIDTH-2:0], 1'b0};
                w_cout   = in[WIDTH-1];
            end
            OP_LSR: begin
                w_result = {1'b0, in[WIDTH-1:1]};
                w_cout   = in[0];
            end
            OP_ASR: begin
                w_result = {in[WIDTH-1], in[WIDTH-1:1]};
                w_cout   = in[0];
            end
            default: begin
                w_result = in;
                w_cout   = 1'b0;
            end
        endcase
    end

    assign w_zero = (w_result == '0);

    // Reset wins over in_valid, so a result accepted on the reset edge is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sout  <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_sout  <= w_result;
            r_cout  <= w_cout;
            r_zero  <= w_zero;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign sout      = r_sout;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign out_valid = r_valid;

`ifndef SYNTHESIS
    a_shift_known: assert property (@(posedge clk) disable iff (reset)
        in_valid |-> !$isunknown(shift))
        else $error("shift opcode is X/Z while in_valid is high");
`endif

endmodule

// File: tb/tb_shifter.sv
// Directed bench for shifter: hand-computed vectors for every opcode, hold, and reset mid-stream.
// Outputs are checked #1 after the rising edge that captures each input.
module tb_shifter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in;
    logic [1:0]  shift;
    logic [15:0] sout;
    logic        cout;
    logic        zero;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    shifter #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in),
        .shift     (shift),
        .sout      (sout),
        .cout      (cout),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge, then step just past the next rising edge.
    task automatic step(input logic rst, input logic v, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        in       = d;
        shift    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 16'hFFFF, 2'b00);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_edge1: got sout=%h cout=%b zero=%b valid=%b, want sout=0000 cout=0 zero=0 valid=0",
                     sout, cout, zero, out_valid);
        end
        step(1'b1, 1'b0, 16'h0000, 2'b00);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_edge2: got sout=%h cout=%b zero=%b valid=%b, want sout=0000 cout=0 zero=0 valid=0",
                     sout, cout, zero, out_valid);
        end
    endtask

    task automatic test_pass();
        step(1'b0, 1'b1, 16'hF0CF, 2'b00);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'hF0CF, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL pass_F0CF: got sout=%h cout=%b zero=%b valid=%b, want sout=f0cf cout=0 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
    endtask

    task automatic test_logical();
        step(1'b0, 1'b1, 16'hF0CF, 2'b01);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'hE19E, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL lsl_F0CF: got sout=%h cout=%b zero=%b valid=%b, want sout=e19e cout=1 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
        step(1'b0, 1'b1, 16'hF0CF, 2'b10);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h7867, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL lsr_F0CF: got sout=%h cout=%b zero=%b valid=%b, want sout=7867 cout=1 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
    endtask

    task automatic test_arith();
        step(1'b0, 1'b1, 16'hF0CF, 2'b11);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'hF867, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL asr_F0CF: got sout=%h cout=%b zero=%b valid=%b, want sout=f867 cout=1 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
        step(1'b0, 1'b1, 16'h7FFE, 2'b11);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h3FFF, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL asr_7FFE: got sout=%h cout=%b zero=%b valid=%b, want sout=3fff cout=0 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
        step(1'b0, 1'b1, 16'hFFFF, 2'b11);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'hFFFF, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL asr_FFFF: got sout=%h cout=%b zero=%b valid=%b, want sout=ffff cout=1 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
    endtask

    task automatic test_zero_hold();
        step(1'b0, 1'b1, 16'h0001, 2'b10);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h0000, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL lsr_0001: got sout=%h cout=%b zero=%b valid=%b, want sout=0000 cout=1 zero=1 valid=1",
                     sout, cout, zero, out_valid);
        end
        step(1'b0, 1'b0, 16'hABCD, 2'b01);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_idle: got sout=%h cout=%b zero=%b valid=%b, want sout=0000 cout=1 zero=1 valid=0",
                     sout, cout, zero, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 16'h1234, 2'b01);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h2468, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_1: got sout=%h cout=%b zero=%b valid=%b, want sout=2468 cout=0 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
        step(1'b0, 1'b1, 16'h8001, 2'b10);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h4000, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_2: got sout=%h cout=%b zero=%b valid=%b, want sout=4000 cout=1 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
        step(1'b0, 1'b1, 16'h8002, 2'b11);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'hC001, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_3: got sout=%h cout=%b zero=%b valid=%b, want sout=c001 cout=0 zero=0 valid=1",
                     sout, cout, zero, out_valid);
        end
        step(1'b1, 1'b1, 16'hFFFF, 2'b00);
        checks++;
        if ({sout, cout, zero, out_valid} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_4_reset: got sout=%h cout=%b zero=%b valid=%b, want sout=0000 cout=0 zero=0 valid=0",
                     sout, cout, zero, out_valid);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in       = 16'h0000;
        shift    = 2'b00;
        test_reset();
        test_pass();
        test_logical();
        test_arith();
        test_zero_hold();
        test_back_to_back();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
